tile_load_ctrl: RTL and testbench

// Fetch sequencer between the AXI read master and the systolic controller's operand buffers.
// On start it issues three AXI read requests in order C, A, B (base addresses from baseaddr_t).

---
 rtl/tile_load_ctrl_pkg.sv | 74 +++++++
 rtl/tile_load_ctrl.sv | 154 +++++++++++++++
 tb/tb_tile_load_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_load_ctrl_pkg.sv
// Shared types for the tile fetch path: AXI request/response structs, compute shape/datatype
// and the per-matrix beat-count helper used by the load sequencer.
package tile_load_ctrl_pkg;

  localparam int DATA_WIDTH     = 256;
  localparam int BUF_AW         = 6;
  localparam int ADDR_W         = 32;
  localparam int AXI_BEAT_BYTES = 32;
  localparam logic [2:0] ARSIZE = 3'd5;

  localparam logic [2:0] SEL_C = 3'b001;
  localparam logic [2:0] SEL_A = 3'b100;
  localparam logic [2:0] SEL_B = 3'b010;

  typedef enum logic [1:0] {
    MAT_A = 2'd0,
    MAT_B = 2'd1,
    MAT_C = 2'd2
  } mat_t;

  typedef enum logic [1:0] {
    M32K16N8  = 2'd0,
    M16K16N16 = 2'd1,
    M8K16N32  = 2'd2
  } shape_t;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } dtype_t;

  typedef struct packed {
    shape_t shape;
    dtype_t dtype;
  } compute_type_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] c;
  } baseaddr_t;

  typedef struct packed {
    logic              request_valid;
    logic [ADDR_W-1:0] base;
    logic [2:0]        sel;
    logic              issend;
    logic [2:0]        burst_size;
    logic [7:0]        burst_num;
  } AXI_out_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  finish;
    logic                  arready;
  } AXI_in_t;

  // A spans M rows and B spans N columns of a K=16 tile; an FP32 row of 16 elements is
  // two beats, and each halving of the element size halves the beat count.
  function automatic logic [6:0] mat_beats(input mat_t mat, input compute_type_t ct);
    logic [6:0] dim;
    if (mat == MAT_C) return 7'd32;
    case (ct.shape)
      M32K16N8:  dim = (mat == MAT_A) ? 7'd32 : 7'd8;
      M16K16N16: dim = 7'd16;
      default:   dim = (mat == MAT_A) ? 7'd8 : 7'd32;
    endcase
    return (dim << 1) >> ct.dtype;
  endfunction

endpackage

// File: rtl/tile_load_ctrl.sv
// Fetch sequencer: issues C, A, B AXI read requests in turn and streams the returned beats
// into the selected operand buffer, pulsing done once the B matrix has landed.
module tile_load_ctrl
  import tile_load_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  compute_type_t         cfg,
  input  baseaddr_t             base,
  output AXI_out_t              axi_out,
  input  AXI_in_t               axi_in,
  output logic                  buf_wr_en,
  output mat_t                  buf_wr_mat,
  output logic [BUF_AW-1:0]     buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ_C = 3'd1,
    S_DAT_C = 3'd2,
    S_REQ_A = 3'd3,
    S_DAT_A = 3'd4,
    S_REQ_B = 3'd5,
    S_DAT_B = 3'd6,
    S_DONE  = 3'd7
  } fetch_state_t;

  fetch_state_t  state, state_nx;
  compute_type_t cfg_q;
  baseaddr_t     base_q;
  mat_t          cur_mat;
  logic [BUF_AW:0] beat_cnt, exp_beats, beats_after;
  logic in_req, in_dat, start_acc, beat_take, beat_over, beat_short;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Handshake: a request is offered (request_valid=1, fields stable) until a cycle with
  // arready=1 and is retired on that edge; a beat transfers on any DAT cycle with valid=1,
  // and finish closes the current matrix on the edge where it is seen.
  always_comb begin
    state_nx = state;
    cur_mat  = MAT_C;
    in_req   = 1'b0;
    in_dat   = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_REQ_C;
      S_REQ_C: begin
        in_req = 1'b1;
        if (axi_in.arready) state_nx = S_DAT_C;
      end
      S_DAT_C: begin
        in_dat = 1'b1;
        if (axi_in.finish) state_nx = S_REQ_A;
      end
      S_REQ_A: begin
        cur_mat = MAT_A;
        in_req  = 1'b1;
        if (axi_in.arready) state_nx = S_DAT_A;
      end
      S_DAT_A: begin
        cur_mat = MAT_A;
        in_dat  = 1'b1;
        if (axi_in.finish) state_nx = S_REQ_B;
      end
      S_REQ_B: begin
        cur_mat = MAT_B;
        in_req  = 1'b1;
        if (axi_in.arready) state_nx = S_DAT_B;
      end
      S_DAT_B: begin
        cur_mat = MAT_B;
        in_dat  = 1'b1;
        if (axi_in.finish) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign exp_beats   = mat_beats(cur_mat, cfg_q);
  assign start_acc   = (state == S_IDLE) && start;
  assign beat_take   = in_dat && axi_in.valid && (beat_cnt < exp_beats);
  assign beat_over   = in_dat && axi_in.valid && (beat_cnt >= exp_beats);
  assign beats_after = beat_cnt + {{BUF_AW{1'b0}}, beat_take};
  assign beat_short  = in_dat && axi_in.finish && (beats_after < exp_beats);

  always_comb begin
    axi_out = '0;
    if (in_req) begin
      axi_out.request_valid = 1'b1;
      axi_out.issend        = 1'b0;
      axi_out.burst_size    = ARSIZE;
      axi_out.burst_num     = {1'b0, exp_beats - 7'd1};
      case (cur_mat)
        MAT_A: begin
          axi_out.base = base_q.a;
          axi_out.sel  = SEL_A;
        end
        MAT_B: begin
          axi_out.base = base_q.b;
          axi_out.sel  = SEL_B;
        end
        default: begin
          axi_out.base = base_q.c;
          axi_out.sel  = SEL_C;
        end
      endcase
    end
  end

  // Beat counter never wraps: surplus beats leave it parked at the expected count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q       <= '0;
      base_q      <= '0;
      beat_cnt    <= '0;
      buf_wr_en   <= 1'b0;
      buf_wr_mat  <= MAT_A;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      err         <= 1'b0;
    end else begin
      buf_wr_en <= beat_take;
      if (beat_take) begin
        buf_wr_mat  <= cur_mat;
        buf_wr_addr <= beat_cnt[BUF_AW-1:0];
        buf_wr_data <= axi_in.data;
      end
      if (in_dat && axi_in.finish) beat_cnt <= '0;
      else if (beat_take)          beat_cnt <= beats_after;
      if (start_acc) begin
        cfg_q  <= cfg;
        base_q <= base;
        err    <= 1'b0;
      end else if (beat_over || beat_short) begin
        err <= 1'b1;
      end
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_tile_load_ctrl.sv
// Bench for tile_load_ctrl: an AXI responder drives requests/beats while a beat-level model
// predicts every buffer write, request field, done pulse and error flag.
module tb_tile_load_ctrl;
  import tile_load_ctrl_pkg::*;

  localparam int EW = 32 + 2 + BUF_AW + DATA_WIDTH;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  start;
  compute_type_t         cfg;
  baseaddr_t             base;
  AXI_out_t              axi_out;
  AXI_in_t               axi_in;
  logic                  buf_wr_en;
  mat_t                  buf_wr_mat;
  logic [BUF_AW-1:0]     buf_wr_addr;
  logic [DATA_WIDTH-1:0] buf_wr_data;
  logic                  busy, done, err;
  logic [2:0]            state_dbg;

  tile_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg(cfg), .base(base),
    .axi_out(axi_out), .axi_in(axi_in),
    .buf_wr_en(buf_wr_en), .buf_wr_mat(buf_wr_mat), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wr_mat_cnt[3];
  int obs_bn[3];
  int obs_bs[3];
  logic [EW-1:0] exp_q[$];

  int k_ar_delay, k_gap, k_b_extra, k_a_short;
  bit k_late, k_glitch, k_abort;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: matrix size in elements times element width in bits, over 256 bits per beat.
  function automatic int tb_beats(input mat_t m, input shape_t s, input dtype_t d);
    int mm, nn, bits, elems;
    case (s)
      M32K16N8:  begin mm = 32; nn = 8;  end
      M16K16N16: begin mm = 16; nn = 16; end
      default:   begin mm = 8;  nn = 32; end
    endcase
    case (d)
      FP32:    bits = 32;
      FP16:    bits = 16;
      INT8:    bits = 8;
      default: bits = 4;
    endcase
    if (m == MAT_C) return (mm * nn * 32) / 256;
    elems = (m == MAT_A) ? mm * 16 : 16 * nn;
    return (elems * bits) / 256;
  endfunction

  // scoreboard: every write must match the head of the expected queue, one cycle after its beat
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        chk("busy_low_with_done", 256'(busy), 256'(0));
      end
      if (axi_out.request_valid) chk("busy_with_req", 256'(busy), 256'(1));
      if (buf_wr_en) begin
        wr_mat_cnt[int'(buf_wr_mat)]++;
        chk("wr_expected", 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_cycle", 256'(cyc), 256'(e[EW-1 -: 32]));
          chk("wr_mat", 256'(buf_wr_mat), 256'(e[DATA_WIDTH+BUF_AW +: 2]));
          chk("wr_addr", 256'(buf_wr_addr), 256'(e[DATA_WIDTH +: BUF_AW]));
          chk("wr_data", buf_wr_data, e[DATA_WIDTH-1:0]);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_axi_out"}, 256'(axi_out), 256'(0));
    chk({tag, "_wr_en"}, 256'(buf_wr_en), 256'(0));
    chk({tag, "_wr_mat"}, 256'(buf_wr_mat), 256'(MAT_A));
    chk({tag, "_wr_addr"}, 256'(buf_wr_addr), 256'(0));
    chk({tag, "_wr_data"}, buf_wr_data, 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_done"}, 256'(done), 256'(0));
    chk({tag, "_err"}, 256'(err), 256'(0));
  endtask

  task automatic do_abort();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      axi_in.valid   = 1'($urandom_range(0, 1));
      axi_in.finish  = 1'($urandom_range(0, 1));
      axi_in.arready = 1'($urandom_range(0, 1));
      axi_in.data    = {8{$urandom}};
      @(negedge clk);
      chk("post_abort_req", 256'(axi_out.request_valid), 256'(0));
      chk("post_abort_busy", 256'(busy), 256'(0));
    end
    axi_in.valid  = 1'b0;
    axi_in.finish = 1'b0;
  endtask

  // driver: one full fetch, acting as the AXI master's response side
  task automatic run_op(input shape_t sh, input dtype_t dt);
    baseaddr_t b;
    mat_t order[3];
    mat_t m;
    int nb, nsend, gap, dc0;
    logic [DATA_WIDTH-1:0] d;
    logic [31:0] eb;
    AXI_out_t snap;
    bit exp_err;
    order = '{MAT_C, MAT_A, MAT_B};
    b.a = $urandom; b.b = $urandom; b.c = $urandom;
    exp_err = (k_b_extra > 0) || (k_a_short > 0);
    dc0 = done_cnt;
    for (int j = 0; j < 3; j++) wr_mat_cnt[j] = 0;
    @(negedge clk);
    chk("idle_before_start", 256'(busy), 256'(0));
    start = 1'b1; cfg.shape = sh; cfg.dtype = dt; base = b;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 256'(busy), 256'(1));
    chk("err_cleared", 256'(err), 256'(0));
    for (int k = 0; k < 3; k++) begin
      m = order[k];
      nb = tb_beats(m, sh, dt);
      nsend = nb + ((m == MAT_B) ? k_b_extra : 0) - ((m == MAT_A) ? k_a_short : 0);
      eb = (m == MAT_A) ? b.a : (m == MAT_B) ? b.b : b.c;
      for (int t = 0; t < 20 && !axi_out.request_valid; t++) @(negedge clk);
      chk("req_seen", 256'(axi_out.request_valid), 256'(1));
      if (!axi_out.request_valid) return;
      chk("req_sel", 256'(axi_out.sel),
          256'((m == MAT_C) ? 3'b001 : (m == MAT_A) ? 3'b100 : 3'b010));
      chk("req_base", 256'(axi_out.base), 256'(eb));
      chk("req_burst_num", 256'(axi_out.burst_num), 256'(nb - 1));
      chk("req_burst_size", 256'(axi_out.burst_size), 256'(5));
      chk("req_issend", 256'(axi_out.issend), 256'(0));
      obs_bn[k] = int'(axi_out.burst_num);
      obs_bs[k] = int'(axi_out.burst_size);
      snap = axi_out;
      gap = (k_ar_delay < 0) ? $urandom_range(0, 3) : k_ar_delay;
      for (int t = 0; t < gap; t++) begin
        axi_in.arready = 1'b0;
        axi_in.valid   = 1'($urandom_range(0, 1));
        if (k_glitch && t == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("req_held", 256'(axi_out), 256'(snap));
      end
      axi_in.arready = 1'b1;
      @(negedge clk);
      axi_in.arready = 1'($urandom_range(0, 1));
      axi_in.valid   = 1'b0;
      chk("req_drop", 256'(axi_out.request_valid), 256'(0));
      for (int i = 0; i < nsend; i++) begin
        gap = (i == 0) ? 0 : (k_gap < 0) ? $urandom_range(0, 2) : k_gap;
        for (int t = 0; t < gap; t++) begin
          axi_in.valid = 1'b0;
          axi_in.finish = 1'b0;
          @(negedge clk);
        end
        if (k_abort && m == MAT_A && i == 2) begin
          do_abort();
          return;
        end
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
        axi_in.data   = d;
        axi_in.valid  = 1'b1;
        axi_in.finish = (i == nsend - 1) && !k_late;
        if (k_glitch && m == MAT_A && i == 1) begin
          start = 1'b1;
          cfg.shape = shape_t'($urandom_range(0, 2));
          cfg.dtype = dtype_t'($urandom_range(0, 3));
          base.a = $urandom;
        end
        if (i < nb) exp_q.push_back({32'(cyc + 1), 2'(m), 6'(i), d});
        @(negedge clk);
        start = 1'b0;
      end
      axi_in.valid  = 1'b0;
      axi_in.finish = 1'b0;
      if (k_late) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        axi_in.finish = 1'b1;
        @(negedge clk);
        axi_in.finish = 1'b0;
      end
    end
    chk("done_pulse", 256'(done), 256'(1));
    chk("busy_at_done", 256'(busy), 256'(0));
    chk("err_at_done", 256'(err), 256'(exp_err));
    @(negedge clk);
    chk("done_low", 256'(done), 256'(0));
    chk("err_sticky", 256'(err), 256'(exp_err));
    chk("done_count", 256'(done_cnt - dc0), 256'(1));
    chk("writes_drained", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic knobs(input int ard, input int gp, input int bx, input int ash,
                       input bit lt, input bit gl, input bit ab);
    k_ar_delay = ard; k_gap = gp; k_b_extra = bx; k_a_short = ash;
    k_late = lt; k_glitch = gl; k_abort = ab;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg = '0; base = '0; axi_in = '0;
    knobs(0, 0, 0, 0, 0, 0, 0);
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // pin the model with hand-computed beat counts
    chk("model_c", 256'(tb_beats(MAT_C, M16K16N16, INT8)), 256'(32));
    chk("model_fp32_a", 256'(tb_beats(MAT_A, M32K16N8, FP32)), 256'(64));
    chk("model_int4_a", 256'(tb_beats(MAT_A, M8K16N32, INT4)), 256'(2));
    chk("model_int4_b", 256'(tb_beats(MAT_B, M8K16N32, INT4)), 256'(8));
    chk("model_fp16_a", 256'(tb_beats(MAT_A, M16K16N16, FP16)), 256'(16));

    // FP32 / M32K16N8, zero-wait
    run_op(M32K16N8, FP32);
    chk("t1_bn_c", 256'(obs_bn[0]), 256'(31));
    chk("t1_bn_a", 256'(obs_bn[1]), 256'(63));
    chk("t1_bn_b", 256'(obs_bn[2]), 256'(15));
    chk("t1_wr_c", 256'(wr_mat_cnt[MAT_C]), 256'(32));
    chk("t1_wr_a", 256'(wr_mat_cnt[MAT_A]), 256'(64));
    chk("t1_wr_b", 256'(wr_mat_cnt[MAT_B]), 256'(16));

    // INT4 / M8K16N32
    run_op(M8K16N32, INT4);
    chk("t2_bn_c", 256'(obs_bn[0]), 256'(31));
    chk("t2_bn_a", 256'(obs_bn[1]), 256'(1));
    chk("t2_bn_b", 256'(obs_bn[2]), 256'(7));
    for (int k = 0; k < 3; k++) chk("t2_bsize", 256'(obs_bs[k]), 256'(5));
    chk("t2_wr_a", 256'(wr_mat_cnt[MAT_A]), 256'(2));

    // FP16 / M16K16N16 with arready held off for 5 cycles
    knobs(5, 0, 0, 0, 0, 0, 0);
    run_op(M16K16N16, FP16);

    // B over-delivers one beat
    knobs(0, -1, 1, 0, 0, 0, 0);
    run_op(M32K16N8, FP32);
    chk("t4_wr_b", 256'(wr_mat_cnt[MAT_B]), 256'(16));
    knobs(-1, -1, 0, 0, 0, 0, 0);
    run_op(M16K16N16, INT8);

    // start pulses while busy
    knobs(2, -1, 0, 0, 0, 1, 0);
    run_op(M32K16N8, FP16);

    // valid 1 on / 2 off, finish on last valid
    knobs(0, 2, 0, 0, 0, 0, 0);
    run_op(M8K16N32, FP32);

    // A under-delivers, finish arrives late
    knobs(1, -1, 0, 1, 1, 0, 0);
    run_op(M16K16N16, INT4);

    // reset during DAT_A, then recover
    knobs(0, -1, 0, 0, 0, 1, 1);
    run_op(M32K16N8, FP32);
    knobs(-1, -1, 0, 0, 0, 0, 0);
    run_op(M8K16N32, INT8);

    for (int r = 0; r < 6; r++) begin
      knobs(-1, -1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      run_op(shape_t'($urandom_range(0, 2)), dtype_t'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
